// File: rtl/signed_or_unsigned_mac_if.sv
// Operand-beat and result handshake bundle for the signed/unsigned MAC.
// slave = the MAC stage, master = upstream producer / downstream consumer.
interface signed_or_unsigned_mac_if #(
    parameter int N     = 8,
    parameter int ACC_W = 20
);
    logic             arg_vld;
    logic             arg_rdy;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             signed_mul;
    logic             last;
    logic             res_vld;
    logic             res_rdy;
    logic [ACC_W-1:0] res;
    logic             overflow;

    modport master (
        output arg_vld, a, b, signed_mul, last, res_rdy,
        input  arg_rdy, res_vld, res, overflow
    );

    modport slave (
        input  arg_vld, a, b, signed_mul, last, res_rdy,
        output arg_rdy, res_vld, res, overflow
    );
endinterface

// File: rtl/signed_or_unsigned_mac.sv
// Two-stage pipelined multiply-accumulate over last-delimited frames,
// signed or unsigned per frame, with sticky overflow and valid/ready flow.
module signed_or_unsigned_mac #(
    parameter int N         = 8,
    parameter int ACC_EXTRA = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    signed_or_unsigned_mac_if.slave  bus
);
    localparam int ACC_W = 2 * N + ACC_EXTRA;
    localparam int MSB   = ACC_W - 1;

    logic                    w_en;
    logic                    w_take;
    logic                    w_mode;
    logic signed [2*N-1:0]   w_prod_s;
    logic        [2*N-1:0]   w_prod_u;
    logic        [ACC_W-1:0] w_p_ext;
    logic        [ACC_W:0]   w_sum_c;
    logic        [ACC_W-1:0] w_sum;
    logic                    w_ovf_beat;

    logic                    r_open;
    logic                    r_mode;
    logic                    r_p_vld;
    logic                    r_p_last;
    logic                    r_p_mode;
    logic        [ACC_W-1:0] r_p;
    logic        [ACC_W-1:0] r_acc;
    logic                    r_sticky;
    logic                    r_res_vld;
    logic        [ACC_W-1:0] r_res;
    logic                    r_ovf;

    // The whole pipe freezes only while a result waits on the consumer.
    assign w_en        = !(r_res_vld && !bus.res_rdy);
    assign bus.arg_rdy = w_en;
    assign w_take      = bus.arg_vld && w_en;
    assign w_mode      = r_open ? r_mode : bus.signed_mul;

    assign w_prod_s = $signed(bus.a) * $signed(bus.b);
    assign w_prod_u = bus.a * bus.b;
    assign w_p_ext  = w_mode ? {{ACC_EXTRA{w_prod_s[2*N-1]}}, w_prod_s}
                             : {{ACC_EXTRA{1'b0}}, w_prod_u};

    assign w_sum_c    = {1'b0, r_acc} + {1'b0, r_p};
    assign w_sum      = w_sum_c[ACC_W-1:0];
    assign w_ovf_beat = r_p_mode
        ? ((r_acc[MSB] == r_p[MSB]) && (w_sum[MSB] != r_acc[MSB]))
        : w_sum_c[ACC_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_open   <= 1'b0;
            r_mode   <= 1'b0;
            r_p_vld  <= 1'b0;
            r_p_last <= 1'b0;
            r_p_mode <= 1'b0;
            r_p      <= '0;
        end else if (w_en) begin
            r_p_vld <= w_take;
            if (w_take) begin
                r_p      <= w_p_ext;
                r_p_last <= bus.last;
                r_p_mode <= w_mode;
                r_mode   <= w_mode;
                r_open   <= !bus.last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_sticky  <= 1'b0;
            r_res_vld <= 1'b0;
            r_res     <= '0;
            r_ovf     <= 1'b0;
        end else if (w_en) begin
            r_res_vld <= r_p_vld && r_p_last;
            if (r_p_vld) begin
                if (r_p_last) begin
                    r_res    <= w_sum;
                    r_ovf    <= r_sticky | w_ovf_beat;
                    r_acc    <= '0;
                    r_sticky <= 1'b0;
                end else begin
                    r_acc    <= w_sum;
                    r_sticky <= r_sticky | w_ovf_beat;
                end
            end
        end
    end

    assign bus.res_vld  = r_res_vld;
    assign bus.res      = r_res;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_signed_or_unsigned_mac.sv
// Scoreboard bench for signed_or_unsigned_mac at n=4, acc_extra=4.
// A reference model queues frame results on acceptance; a monitor pops them.
module tb_signed_or_unsigned_mac;
    localparam int N     = 4;
    localparam int ACC_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    signed_or_unsigned_mac_if #(.N(N), .ACC_W(ACC_W)) bus ();

    signed_or_unsigned_mac #(.N(N), .ACC_EXTRA(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [ACC_W:0] sb_q[$];

    int   m_acc  = 0;
    logic m_open = 1'b0;
    logic m_mode = 1'b0;
    logic m_ovf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_beat(input logic [3:0] ia, input logic [3:0] ib,
                              input logic sm, input logic lst);
        int pa, pb, sum;
        logic [ACC_W-1:0] w;
        if (!m_open) m_mode = sm;
        pa  = (m_mode && ia[3]) ? int'(ia) - 16 : int'(ia);
        pb  = (m_mode && ib[3]) ? int'(ib) - 16 : int'(ib);
        sum = m_acc + pa * pb;
        if (m_mode ? (sum > 2047 || sum < -2048) : (sum > 4095))
            m_ovf = 1'b1;
        w = 12'(sum);
        m_acc = (m_mode && w[11]) ? int'(w) - 4096 : int'(w);
        if (lst) begin
            sb_q.push_back({m_ovf, w});
            m_acc  = 0;
            m_ovf  = 1'b0;
            m_open = 1'b0;
        end else begin
            m_open = 1'b1;
        end
    endtask

    task automatic send_beat(input logic [3:0] ia, input logic [3:0] ib,
                             input logic sm, input logic lst);
        int w;
        bus.a          = ia;
        bus.b          = ib;
        bus.signed_mul = sm;
        bus.last       = lst;
        bus.arg_vld    = 1'b1;
        w = 0;
        forever begin
            @(negedge clk);
            if (bus.arg_rdy) break;
            w++;
            if (w > 50) begin
                chk("arg_rdy_timeout", 32'd0, 32'd1);
                bus.arg_vld = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_beat(ia, ib, sm, lst);
        #1;
        bus.arg_vld = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.res_vld && bus.res_rdy) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_res", 32'd1, 32'd0);
            end else begin
                logic [ACC_W:0] e;
                e = sb_q.pop_front();
                chk("res", 32'(bus.res), 32'(e[ACC_W-1:0]));
                chk("overflow", 32'(bus.overflow), 32'(e[ACC_W]));
            end
        end
    end

    initial begin
        bus.arg_vld    = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.signed_mul = 1'b0;
        bus.last       = 1'b0;
        bus.res_rdy    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_vld", 32'(bus.res_vld), 32'd0);
        chk("rst_res", 32'(bus.res), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_arg_rdy", 32'(bus.arg_rdy), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // unsigned frame plus two-register latency
        send_beat(4'd15, 4'd15, 1'b0, 1'b0);
        send_beat(4'd15, 4'd15, 1'b0, 1'b1);
        chk("lat_edge1", 32'(bus.res_vld), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_edge2", 32'(bus.res_vld), 32'd1);
        chk("lat_res", 32'(bus.res), 32'h1C2);

        // signed frame, then mode flip ignored mid-frame
        send_beat(4'h8, 4'h8, 1'b1, 1'b0);
        send_beat(4'h8, 4'h7, 1'b0, 1'b0);
        send_beat(4'h7, 4'h7, 1'b0, 1'b1);
        send_beat(4'hF, 4'hF, 1'b1, 1'b0);
        send_beat(4'h2, 4'h3, 1'b0, 1'b0);
        send_beat(4'hF, 4'h1, 1'b0, 1'b1);

        // back-to-back single-beat signed frames
        send_beat(4'hF, 4'h7, 1'b1, 1'b1);
        send_beat(4'h3, 4'hE, 1'b1, 1'b1);
        chk("b2b_first", 32'(bus.res_vld), 32'd1);
        @(posedge clk);
        #1;
        chk("b2b_second", 32'(bus.res_vld), 32'd1);

        // overflow frames and sticky clear
        for (int i = 0; i < 19; i++)
            send_beat(4'd15, 4'd15, 1'b0, i == 18);
        for (int i = 0; i < 32; i++)
            send_beat(4'h8, 4'h8, 1'b1, i == 31);
        send_beat(4'h1, 4'h1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // backpressure
        bus.res_rdy = 1'b0;
        send_beat(4'h3, 4'h3, 1'b0, 1'b1);
        send_beat(4'h2, 4'h2, 1'b0, 1'b0);
        fork
            send_beat(4'h2, 4'h2, 1'b0, 1'b1);
        join_none
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_arg_rdy", 32'(bus.arg_rdy), 32'd0);
            chk("bp_res_vld", 32'(bus.res_vld), 32'd1);
            chk("bp_res", 32'(bus.res), 32'd9);
            chk("bp_ovf", 32'(bus.overflow), 32'd0);
        end
        bus.res_rdy = 1'b1;
        wait fork;
        repeat (3) @(posedge clk);
        #1;

        // reset mid-frame
        send_beat(4'h5, 4'h5, 1'b0, 1'b0);
        send_beat(4'h5, 4'h5, 1'b0, 1'b0);
        chk("pre_rst_res", 32'(bus.res != '0), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_res_vld", 32'(bus.res_vld), 32'd0);
        chk("async_res", 32'(bus.res), 32'd0);
        chk("async_ovf", 32'(bus.overflow), 32'd0);
        m_acc  = 0;
        m_open = 1'b0;
        m_ovf  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_beat(4'h2, 4'h3, 1'b0, 1'b1);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++)
            @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
